// File: rtl/bloom_pkg.sv
// Shared types and defaults for the Bloom-filter membership engine.
// Latency: none (declarations only).
// Backpressure: n/a.
package bloom_pkg;

    // Request opcodes carried on req_op.
    typedef enum logic [1:0] {
        CHECK  = 2'b00,
        INSERT = 2'b01,
        CLEAR  = 2'b10,
        DELETE = 2'b11
    } op_e;

    // Engine sequencing: one op walks IDLE -> HASH -> APPLY -> RESP.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        HASH  = 2'b01,
        APPLY = 2'b10,
        RESP  = 2'b11
    } state_e;

    // Default packed odd multipliers for three 8-bit lanes; lane i = [i*8 +: 8].
    localparam logic [23:0] BLOOM_HASH_KEYS_DFLT = 24'h3B65A7;

endpackage

// File: rtl/bloom_filter_engine_if.sv
// Request/response handshake bundle for the Bloom-filter engine.
// Latency: none (wires only).
// Backpressure: req_valid/req_ready on requests, rsp_valid/rsp_ready on responses.
// Ports: req_valid, req_ready, req_op[1:0], req_data[DATA_W-1:0],
//        rsp_valid, rsp_ready, rsp_hit, rsp_err.
// master = requester side (testbench/core), slave = engine side.
interface bloom_filter_engine_if #(
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_hit;
    logic              rsp_err;

    modport master (
        output req_valid, req_op, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_err
    );
endinterface

// File: rtl/bloom_hash_lane.sv
// One multiplicative hash lane: idx = (data * KEY)[DATA_W-1 -: IDX_W].
// Latency: combinational.
// Backpressure: none.
// Ports: data_i[DATA_W-1:0] key in, idx_o[IDX_W-1:0] filter index out.
module bloom_hash_lane #(
    parameter int                DATA_W = 8,
    parameter int                IDX_W  = 4,
    parameter logic [DATA_W-1:0] KEY    = '1
) (
    input  logic [DATA_W-1:0] data_i,
    output logic [IDX_W-1:0]  idx_o
);

    logic [2*DATA_W-1:0] prod;
    logic                unused_prod;

    // Zero-extend both operands so the full double-width product is formed.
    assign prod  = {{DATA_W{1'b0}}, data_i} * {{DATA_W{1'b0}}, KEY};
    // Take the top IDX_W bits of the low half: better mixing than the LSBs.
    assign idx_o = prod[DATA_W-1 -: IDX_W];

    // Upper product bits are intentionally dropped.
    assign unused_prod = ^prod;

endmodule

// File: rtl/bloom_filter_engine.sv
// Bloom-filter membership engine: K hash lanes over an M-bit filter; CHECK/INSERT/CLEAR(/DELETE).
// Latency: accept at cycle 0 -> rsp_valid at cycle 3; one op in flight.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready.
// Ports: clk, reset_n (async active-low), bus (slave modport: req_*/rsp_*),
//        filter_o[FILTER_W-1:0] live filter vector, ins_count[INS_CNT_W-1:0] saturating insert count.
// Build option: define BLOOM_COUNTING_EN to replace each filter bit with a CNT_W counter and
// enable DELETE; otherwise DELETE is rejected with rsp_err.
module bloom_filter_engine
    import bloom_pkg::*;
#(
    parameter int                         DATA_W    = 8,
    parameter int                         FILTER_W  = 16,
    parameter int                         NUM_HASH  = 3,
    parameter logic [NUM_HASH*DATA_W-1:0] HASH_KEYS = BLOOM_HASH_KEYS_DFLT,
    parameter int                         CNT_W     = 4,
    parameter int                         INS_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    bloom_filter_engine_if.slave bus,
    output logic [FILTER_W-1:0]  filter_o,
    output logic [INS_CNT_W-1:0] ins_count
);

    localparam int IDX_W = $clog2(FILTER_W);
    localparam logic [INS_CNT_W-1:0] INS_ONE = {{(INS_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [INS_CNT_W-1:0] INS_MAX = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                          state_q, state_d;
    op_e                             op_q, op_d;
    logic [DATA_W-1:0]               data_q, data_d;
    logic [NUM_HASH-1:0][IDX_W-1:0]  idx_q, idx_d;
    logic [INS_CNT_W-1:0]            ins_q, ins_d;
    logic                            hit_q, hit_d;
    logic                            err_q, err_d;

    logic [NUM_HASH-1:0][IDX_W-1:0]  idx_c;       // combinational lane outputs
    logic [FILTER_W-1:0]             idx_mask;    // union of indexed bits (dedups lanes)
    logic [FILTER_W-1:0]             filter_bits; // pre-op membership view
    logic                            all_set;
    logic                            req_ready_c;
    logic                            rsp_valid_c;

`ifdef BLOOM_COUNTING_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [FILTER_W-1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        filter_bits = '0;
        for (int j = 0; j < FILTER_W; j++) begin
            filter_bits[j] = (cnt_q[j] != '0);
        end
    end
`else
    logic [FILTER_W-1:0] filter_q, filter_d;

    assign filter_bits = filter_q;
`endif

    // ------------------------------------------------------------------
    // Hash lanes run off the latched key so later req_data edits are ignored.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_HASH; g++) begin : g_lane
        bloom_hash_lane #(
            .DATA_W (DATA_W),
            .IDX_W  (IDX_W),
            .KEY    (HASH_KEYS[g*DATA_W +: DATA_W])
        ) u_lane (
            .data_i (data_q),
            .idx_o  (idx_c[g])
        );
    end

    // Lanes landing on the same index collapse into one mask bit, so each
    // bit/counter is touched exactly once per op.
    always_comb begin
        idx_mask = '0;
        for (int i = 0; i < NUM_HASH; i++) begin
            idx_mask[idx_q[i]] = 1'b1;
        end
    end

    assign all_set = ((filter_bits & idx_mask) == idx_mask);

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        idx_d       = idx_q;
        ins_d       = ins_q;
        hit_d       = hit_q;
        err_d       = err_q;
`ifdef BLOOM_COUNTING_EN
        cnt_d       = cnt_q;
`else
        filter_d    = filter_q;
`endif
        req_ready_c = 1'b0;
        rsp_valid_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    op_d    = op_e'(bus.req_op);
                    data_d  = bus.req_data;
                    state_d = HASH;
                end
            end

            HASH: begin
                idx_d   = idx_c;
                state_d = APPLY;
            end

            APPLY: begin
                hit_d   = all_set;
                err_d   = 1'b0;
                state_d = RESP;
                unique case (op_q)
                    CHECK: begin
                    end

                    INSERT: begin
`ifdef BLOOM_COUNTING_EN
                        for (int j = 0; j < FILTER_W; j++) begin
                            if (idx_mask[j] && (cnt_q[j] != CNT_MAX)) begin
                                cnt_d[j] = cnt_q[j] + CNT_ONE;
                            end
                        end
`else
                        filter_d = filter_q | idx_mask;
`endif
                        if (ins_q != INS_MAX) begin
                            ins_d = ins_q + INS_ONE;
                        end
                    end

                    CLEAR: begin
                        hit_d = 1'b0;
                        ins_d = '0;
`ifdef BLOOM_COUNTING_EN
                        cnt_d = '0;
`else
                        filter_d = '0;
`endif
                    end

                    DELETE: begin
`ifdef BLOOM_COUNTING_EN
                        if (all_set) begin
                            // Saturated counters have lost their true count and stay put.
                            for (int j = 0; j < FILTER_W; j++) begin
                                if (idx_mask[j] && (cnt_q[j] != CNT_MAX)) begin
                                    cnt_d[j] = cnt_q[j] - CNT_ONE;
                                end
                            end
                        end else begin
                            err_d = 1'b1;
                        end
`else
                        hit_d = 1'b0;
                        err_d = 1'b1;
`endif
                    end

                    default: begin
                    end
                endcase
            end

            RESP: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= CHECK;
            data_q   <= '0;
            idx_q    <= '0;
            ins_q    <= '0;
            hit_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef BLOOM_COUNTING_EN
            cnt_q    <= '0;
`else
            filter_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            ins_q    <= ins_d;
            hit_q    <= hit_d;
            err_q    <= err_d;
`ifdef BLOOM_COUNTING_EN
            cnt_q    <= cnt_d;
`else
            filter_q <= filter_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_hit   = hit_q;
    assign bus.rsp_err   = err_q;
    assign filter_o      = filter_bits;
    assign ins_count     = ins_q;

endmodule

// File: tb/tb_bloom_filter_engine.sv
// Testbench for bloom_filter_engine: directed ops plus a short model-checked random stream.
// Latency: n/a.
// Backpressure: exercises rsp_ready stalls and requests offered while busy.
module tb_bloom_filter_engine;
    import bloom_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] filter_o;
    logic [15:0] ins_count;

    always #5 clk = ~clk;

    bloom_filter_engine_if #(.DATA_W(8)) bus ();

    bloom_filter_engine dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .filter_o  (filter_o),
        .ins_count (ins_count)
    );

    typedef struct {
        logic        hit;
        logic        err;
        logic [15:0] filt;
        logic [15:0] ins;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    logic prev_vld = 1'b0;

    // Reference model state for the random stream.
    logic [15:0] m_filt;
    logic [15:0] m_ins;

    always @(posedge clk) cycle = cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: latency on the rising edge of rsp_valid, contents at handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            prev_vld = 1'b0;
        end else begin
            if (bus.rsp_valid && !prev_vld) begin
                if (sb.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL unexpected_rsp: rsp_valid=1 required 0 at cycle %0d", cycle);
                end else begin
                    chk("latency", 32'(cycle - sb[0].acc), 32'd3);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready && sb.size() > 0) begin
                e = sb.pop_front();
                chk("rsp_hit",   {31'd0, bus.rsp_hit}, {31'd0, e.hit});
                chk("rsp_err",   {31'd0, bus.rsp_err}, {31'd0, e.err});
                chk("filter_o",  {16'd0, filter_o},    {16'd0, e.filt});
                chk("ins_count", {16'd0, ins_count},   {16'd0, e.ins});
            end
            prev_vld = bus.rsp_valid;
        end
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] data, input logic want_rsp,
                         input logic hit, input logic err, input logic [15:0] filt,
                         input logic [15:0] ins);
        int n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_data  = data;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL accept_timeout: req_ready=0 required 1");
            bus.req_valid = 1'b0;
            return;
        end
        if (want_rsp) sb.push_back('{hit, err, filt, ins, cycle});
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        // Scribble the request bus: the engine must use its latched copy.
        bus.req_data  = ~data;
        bus.req_op    = ~op;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL rsp_timeout: %0d responses outstanding required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic op_exp(input logic [1:0] op, input logic [7:0] data, input logic hit,
                          input logic err, input logic [15:0] filt, input logic [15:0] ins);
        issue(op, data, 1'b1, hit, err, filt, ins);
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        chk({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        chk({tag, "_rsp_hit"},   {31'd0, bus.rsp_hit},   32'd0);
        chk({tag, "_rsp_err"},   {31'd0, bus.rsp_err},   32'd0);
        chk({tag, "_filter_o"},  {16'd0, filter_o},      32'd0);
        chk({tag, "_ins_count"}, {16'd0, ins_count},     32'd0);
    endtask

    function automatic logic [15:0] mask_of(input logic [7:0] d);
        logic [7:0]  keys [3];
        logic [15:0] p;
        logic [15:0] m;
        keys[0] = 8'hA7;
        keys[1] = 8'h65;
        keys[2] = 8'h3B;
        m = '0;
        for (int k = 0; k < 3; k++) begin
            p = 16'(d) * 16'(keys[k]);
            m[(p >> 4) & 16'hF] = 1'b1;
        end
        return m;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  rop;
        logic [7:0]  rdat;
        logic [15:0] msk;
        logic        mhit;
        logic        merr;

        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_data  = 8'h00;
        bus.rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Basic insert/check: 0x01 -> {10,6,3}, 0x02 -> {4,12,7}
        op_exp(INSERT, 8'h01, 1'b0, 1'b0, 16'h0448, 16'd1);
        op_exp(CHECK,  8'h01, 1'b1, 1'b0, 16'h0448, 16'd1);
        op_exp(CHECK,  8'h02, 1'b0, 1'b0, 16'h0448, 16'd1);

        // Response stall with a competing request offered
        bus.rsp_ready = 1'b0;
        issue(CHECK, 8'h01, 1'b1, 1'b1, 1'b0, 16'h0448, 16'd1);
        for (int n = 0; n < 20 && !bus.rsp_valid; n++) @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("stall_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("stall_rsp_hit",   {31'd0, bus.rsp_hit},   32'd1);
            chk("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
            bus.req_valid = 1'b1;
            bus.req_op    = INSERT;
            bus.req_data  = 8'h02;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        wait_idle();
        op_exp(CHECK,  8'h02, 1'b0, 1'b0, 16'h0448, 16'd1);

        op_exp(INSERT, 8'h02, 1'b0, 1'b0, 16'h14D8, 16'd2);
        op_exp(INSERT, 8'h01, 1'b1, 1'b0, 16'h14D8, 16'd3);
        op_exp(CLEAR,  8'h00, 1'b0, 1'b0, 16'h0000, 16'd0);

        // Reset while in HASH: op aborted, no response
        op_exp(INSERT, 8'h01, 1'b0, 1'b0, 16'h0448, 16'd1);
        issue(INSERT, 8'h02, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check_reset_outputs("post_reset");

`ifdef BLOOM_COUNTING_EN
        op_exp(INSERT, 8'h01, 1'b0, 1'b0, 16'h0448, 16'd1);
        op_exp(INSERT, 8'h01, 1'b1, 1'b0, 16'h0448, 16'd2);
        op_exp(DELETE, 8'h01, 1'b1, 1'b0, 16'h0448, 16'd2);
        op_exp(DELETE, 8'h01, 1'b1, 1'b0, 16'h0000, 16'd2);
        op_exp(DELETE, 8'h01, 1'b0, 1'b1, 16'h0000, 16'd2);
`else
        op_exp(INSERT, 8'h01, 1'b0, 1'b0, 16'h0448, 16'd1);
        op_exp(DELETE, 8'h01, 1'b0, 1'b1, 16'h0448, 16'd1);
        op_exp(DELETE, 8'h02, 1'b0, 1'b1, 16'h0448, 16'd1);
`endif

        // Random stream against the bench model
        op_exp(CLEAR, 8'h00, 1'b0, 1'b0, 16'h0000, 16'd0);
        m_filt = '0;
        m_ins  = '0;
        for (int r = 0; r < 40; r++) begin
`ifdef BLOOM_COUNTING_EN
            rop = 2'($urandom_range(0, 2));
`else
            rop = 2'($urandom_range(0, 3));
`endif
            rdat = 8'($urandom_range(0, 255));
            msk  = mask_of(rdat);
            mhit = ((m_filt & msk) == msk);
            merr = 1'b0;
            case (rop)
                2'b01: begin
                    m_filt = m_filt | msk;
                    if (m_ins != 16'hFFFF) m_ins = m_ins + 16'd1;
                end
                2'b10: begin
                    m_filt = '0;
                    m_ins  = '0;
                    mhit   = 1'b0;
                end
                2'b11: begin
                    mhit = 1'b0;
                    merr = 1'b1;
                end
                default: begin
                end
            endcase
            op_exp(rop, rdat, mhit, merr, m_filt, m_ins);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
